fir_chan_arb: RTL and testbench

FIR_CHAN_ARB -- requirements
Module: fir_chan_arb

---
 rtl/fir_chan_arb.sv | 91 +++++++++
 tb/tb_fir_chan_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_chan_arb.sv
// fir_chan_arb: round-robin arbiter feeding one shared FIR from two channels, results routed back by tag.
// Optional macro FIR_ARB_STATS_EN builds the saturating per-channel accept counters.
module fir_chan_arb #(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] s0_tdata,
    input  logic       s0_tvalid,
    output logic       s0_tready,
    input  logic [5:0] s1_tdata,
    input  logic       s1_tvalid,
    output logic       s1_tready,
    output logic [5:0] fir_tdata,
    output logic       fir_tvalid,
    input  logic       fir_tready,
    input  logic [7:0] fir_result,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tid,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nxt;
    logic rr, id, g0, g1, fir_hs;
    logic [5:0] hold;
    logic [LATENCY-1:0] vld, tid;

    assign g0 = s0_tvalid && (!s1_tvalid || !rr);
    assign g1 = s1_tvalid && (!s0_tvalid || rr);
    always_comb begin
        state_nxt = state;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        fir_tvalid = 1'b0;
        if (state == IDLE) begin
            s0_tready = rst_n && g0;
            s1_tready = rst_n && g1;
            state_nxt = (g0 || g1) ? ISSUE : IDLE;
        end else begin
            fir_tvalid = 1'b1;
            state_nxt = fir_tready ? IDLE : ISSUE;
        end
    end
    assign fir_hs = fir_tvalid && fir_tready;
    assign fir_tdata = hold;
    assign m_tvalid = vld[LATENCY-1];
    assign m_tdata = m_tvalid ? fir_result : 8'd0;
    assign m_tid = m_tvalid && tid[LATENCY-1];

    // Tag line shifts every cycle so a result slot lines up with the FIR's fixed latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr <= 1'b0;
            id <= 1'b0;
            hold <= 6'd0;
            vld <= '0;
            tid <= '0;
        end else begin
            state <= state_nxt;
            if (s0_tready || s1_tready) begin
                hold <= s1_tready ? s1_tdata : s0_tdata;
                id <= s1_tready;
            end
            if (fir_hs) rr <= !id;
            vld[0] <= fir_hs;
            tid[0] <= id;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                tid[i] <= tid[i-1];
            end
        end
    end

`ifdef FIR_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (s0_tready && cnt0 != 8'hff) cnt0 <= cnt0 + 8'd1;
            if (s1_tready && cnt1 != 8'hff) cnt1 <= cnt1 + 8'd1;
        end
    end
`else
    assign cnt0 = 8'd0;
    assign cnt1 = 8'd0;
`endif
endmodule

// File: tb/tb_fir_chan_arb.sv
// tb_fir_chan_arb: directed and randomized checks of fir_chan_arb against a transaction-level model.
module tb_fir_chan_arb;
    localparam int LAT = 4;
`ifdef FIR_ARB_STATS_EN
    localparam logic [7:0] SAT1 = 8'd255;
`else
    localparam logic [7:0] SAT1 = 8'd0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic [5:0] s0_tdata = '0, s1_tdata = '0;
    logic s0_tvalid = 1'b0, s1_tvalid = 1'b0, fir_tready = 1'b0;
    logic s0_tready, s1_tready, fir_tvalid, m_tvalid, m_tid;
    logic [5:0] fir_tdata;
    logic [7:0] fir_result = '0, m_tdata, cnt0, cnt1;
    always #5 clk = ~clk;

    fir_chan_arb #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .fir_tdata(fir_tdata), .fir_tvalid(fir_tvalid), .fir_tready(fir_tready),
        .fir_result(fir_result), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tid(m_tid),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    int checks = 0, failures = 0, cyc = 0;
    typedef struct {int due; bit id;} res_t;
    res_t q[$];
    bit m_busy, m_rr, m_id;
    logic [5:0] m_hold;
    int m_c0, m_c1;
    bit exp_r0, exp_r1, exp_fv, exp_mv, exp_mid;
    logic [5:0] exp_fd;
    logic [7:0] exp_md, exp_c0, exp_c1;

    task automatic model_reset();
        m_busy = 0; m_rr = 0; m_id = 0; m_hold = '0; m_c0 = 0; m_c1 = 0;
        q.delete();
    endtask

    task automatic eval();
        exp_r0 = !m_busy && s0_tvalid && (!s1_tvalid || !m_rr);
        exp_r1 = !m_busy && s1_tvalid && (!s0_tvalid || m_rr);
        exp_fv = m_busy;
        exp_fd = m_hold;
        exp_mv = q.size() != 0 && q[0].due == cyc;
        exp_mid = exp_mv && q[0].id;
        exp_md = fir_result;
        exp_c0 = 8'(m_c0);
        exp_c1 = 8'(m_c1);
    endtask

    task automatic advance();
        if (exp_mv) void'(q.pop_front());
        if (m_busy && fir_tready) begin
            q.push_back('{due: cyc + LAT, id: m_id});
            m_rr = !m_id;
            m_busy = 0;
        end else if (exp_r0 || exp_r1) begin
            m_busy = 1;
            m_id = exp_r1;
            m_hold = exp_r1 ? s1_tdata : s0_tdata;
`ifdef FIR_ARB_STATS_EN
            if (exp_r0 && m_c0 < 255) m_c0++;
            if (exp_r1 && m_c1 < 255) m_c1++;
`endif
        end
        cyc++;
    endtask

    task automatic drive(input bit v0, input logic [5:0] d0, input bit v1, input logic [5:0] d1, input bit fr);
        @(negedge clk);
        s0_tvalid = v0; s0_tdata = d0; s1_tvalid = v1; s1_tdata = d1; fir_tready = fr;
        fir_result = 8'($urandom);
        #1;
        eval();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; s0_tvalid = 0; s1_tvalid = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        s0_tvalid = 1; s1_tvalid = 1; fir_tready = 1; fir_result = 8'ha5;
        #12;
        checks++; if ({s0_tready, s1_tready, fir_tvalid, m_tvalid, m_tid} !== 5'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=00000", {s0_tready, s1_tready, fir_tvalid, m_tvalid, m_tid}); end
        checks++; if (fir_tdata !== 6'd0) begin failures++; $display("FAIL reset_fir_tdata got=%h exp=00", fir_tdata); end
        checks++; if (m_tdata !== 8'd0) begin failures++; $display("FAIL reset_m_tdata got=%h exp=00", m_tdata); end
        checks++; if ({cnt0, cnt1} !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", {cnt0, cnt1}); end
        @(negedge clk);
        rst_n = 1; s1_tvalid = 0; s0_tdata = 6'h09;
        #1;
        model_reset();
        eval();
        checks++; if (s0_tready !== 1'b1) begin failures++; $display("FAIL first_grant got=%b exp=1", s0_tready); end
        advance();
        drive(0, 0, 0, 0, 1);
        checks++; if (fir_tvalid !== 1'b1 || fir_tdata !== 6'h09) begin failures++; $display("FAIL first_issue got=%b/%h exp=1/09", fir_tvalid, fir_tdata); end
        advance();
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 6'h15, 0, 0, 1);
        checks++; if (s0_tready !== 1'b1 || s1_tready !== 1'b0) begin failures++; $display("FAIL single_grant got=%b%b exp=10", s0_tready, s1_tready); end
        advance();
        drive(0, 0, 0, 0, 1);
        checks++; if (fir_tvalid !== 1'b1 || fir_tdata !== 6'h15 || s0_tready !== 1'b0) begin failures++; $display("FAIL single_issue got=%b/%h/%b exp=1/15/0", fir_tvalid, fir_tdata, s0_tready); end
        advance();
        for (int i = 1; i <= LAT; i++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (m_tvalid !== (i == LAT)) begin failures++; $display("FAIL single_m_tvalid_%0d got=%b exp=%b", i, m_tvalid, i == LAT); end
            if (i == LAT) begin
                checks++; if (m_tid !== 1'b0 || m_tdata !== fir_result) begin failures++; $display("FAIL single_result got=%b/%h exp=0/%h", m_tid, m_tdata, fir_result); end
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        int gch[$], gcy[$], tids[$];
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(c < 8, 6'($urandom), c < 8, 6'($urandom), 1);
            checks++; if (s0_tready !== exp_r0 || s1_tready !== exp_r1) begin failures++; $display("FAIL rr_tready_c%0d got=%b%b exp=%b%b", c, s0_tready, s1_tready, exp_r0, exp_r1); end
            if (s0_tready || s1_tready) begin gch.push_back(int'(s1_tready)); gcy.push_back(c); end
            if (m_tvalid) tids.push_back(int'(m_tid));
            advance();
        end
        checks++; if (gch.size() != 4 || tids.size() != 4) begin failures++; $display("FAIL rr_counts got=%0d/%0d exp=4/4", gch.size(), tids.size()); end
        for (int i = 0; i < 4 && i < gch.size() && i < tids.size(); i++) begin
            checks++; if (gch[i] != i % 2 || gcy[i] != 2 * i || tids[i] != i % 2) begin failures++; $display("FAIL rr_seq_%0d got=ch%0d@%0d tid%0d exp=ch%0d@%0d tid%0d", i, gch[i], gcy[i], tids[i], i % 2, 2 * i, i % 2); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 6'h2a, 0, 0, 0);
        checks++; if (s0_tready !== 1'b1) begin failures++; $display("FAIL stall_grant got=%b exp=1", s0_tready); end
        advance();
        for (int k = 0; k < 6; k++) begin
            drive(1'($urandom), 6'($urandom), 1'($urandom), 6'($urandom), k == 5);
            checks++; if (fir_tvalid !== 1'b1 || fir_tdata !== 6'h2a || s0_tready !== 1'b0 || s1_tready !== 1'b0) begin failures++; $display("FAIL stall_hold_%0d got=%b/%h/%b%b exp=1/2a/00", k, fir_tvalid, fir_tdata, s0_tready, s1_tready); end
            advance();
        end
        drive(0, 0, 0, 0, 1);
        checks++; if (fir_tvalid !== 1'b0 || fir_tdata !== 6'h2a) begin failures++; $display("FAIL stall_release got=%b/%h exp=0/2a", fir_tvalid, fir_tdata); end
        advance();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        drive(0, 0, 1, 6'h33, 1); advance();
        drive(0, 0, 0, 0, 1); advance();
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++; if ({fir_tvalid, m_tvalid, m_tid, s0_tready, s1_tready} !== 5'b0 || fir_tdata !== 6'd0 || m_tdata !== 8'd0) begin failures++; $display("FAIL inflight_reset got=%b/%h/%h exp=0/00/00", {fir_tvalid, m_tvalid, m_tid, s0_tready, s1_tready}, fir_tdata, m_tdata); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < LAT + 4; i++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL inflight_pulse_%0d got=%b exp=0", i, m_tvalid); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 6'($urandom), 1'($urandom), 6'($urandom), $urandom_range(0, 9) < 7);
            checks++; if (s0_tready !== exp_r0 || s1_tready !== exp_r1) begin failures++; $display("FAIL rand_tready_c%0d got=%b%b exp=%b%b", c, s0_tready, s1_tready, exp_r0, exp_r1); end
            checks++; if (fir_tvalid !== exp_fv || fir_tdata !== exp_fd) begin failures++; $display("FAIL rand_fir_c%0d got=%b/%h exp=%b/%h", c, fir_tvalid, fir_tdata, exp_fv, exp_fd); end
            checks++; if (m_tvalid !== exp_mv) begin failures++; $display("FAIL rand_m_tvalid_c%0d got=%b exp=%b", c, m_tvalid, exp_mv); end
            if (exp_mv) begin
                checks++; if (m_tid !== exp_mid || m_tdata !== exp_md) begin failures++; $display("FAIL rand_result_c%0d got=%b/%h exp=%b/%h", c, m_tid, m_tdata, exp_mid, exp_md); end
            end
            checks++; if (cnt0 !== exp_c0 || cnt1 !== exp_c1) begin failures++; $display("FAIL rand_cnt_c%0d got=%h/%h exp=%h/%h", c, cnt0, cnt1, exp_c0, exp_c1); end
            advance();
        end
    endtask

    task automatic test_counters();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive(0, 0, 1, 6'($urandom), 1);
            advance();
        end
        drive(0, 0, 0, 0, 1);
        checks++; if (cnt1 !== SAT1 || cnt1 !== exp_c1) begin failures++; $display("FAIL cnt1_sat got=%0d exp=%0d", cnt1, SAT1); end
        checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL cnt0_idle got=%0d exp=0", cnt0); end
        advance();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_inflight();
        test_random();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
